// File: rtl/cache_types.sv
// Shared constants, FSM state type and address-field helpers for the 2-way L1 cache.
package cache_types;

    localparam int unsigned s_index   = 3;
    localparam int unsigned s_offset  = 5;
    localparam int unsigned s_tag     = 32 - s_offset - s_index;
    localparam int unsigned num_sets  = 1 << s_index;
    localparam int unsigned line_bits = 8 << s_offset;
    localparam int unsigned word_sel  = s_offset - 2;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FILL
    } cache_state_t;

    function automatic logic [s_tag-1:0] get_tag(input logic [31:0] addr);
        return addr[31 -: s_tag];
    endfunction

    function automatic logic [s_index-1:0] get_index(input logic [31:0] addr);
        return addr[s_offset +: s_index];
    endfunction

    function automatic logic [word_sel-1:0] get_word(input logic [31:0] addr);
        return addr[s_offset-1:2];
    endfunction

    // Line-aligned physical address for a given tag/set pair.
    function automatic logic [31:0] line_addr(input logic [s_tag-1:0]   tag,
                                              input logic [s_index-1:0] index);
        return {tag, index, {s_offset{1'b0}}};
    endfunction

endpackage

// File: rtl/l1_cache_2way_if.sv
// CPU-side word handshake and memory-side line handshake bundled for the cache.
interface l1_cache_2way_if;
    import cache_types::*;

    logic                 mem_read;
    logic                 mem_write;
    logic [3:0]           mem_byte_enable;
    logic [31:0]          mem_address;
    logic [31:0]          mem_wdata;
    logic [31:0]          mem_rdata;
    logic                 mem_resp;

    logic                 pmem_read;
    logic                 pmem_write;
    logic [31:0]          pmem_address;
    logic [line_bits-1:0] pmem_wdata;
    logic [line_bits-1:0] pmem_rdata;
    logic                 pmem_resp;

    // The cache itself.
    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  pmem_rdata, pmem_resp,
        output mem_rdata, mem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    // The environment: CPU plus physical memory.
    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output pmem_rdata, pmem_resp,
        input  mem_rdata, mem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );

endinterface

// File: rtl/cache_array.sv
// Small register array: asynchronous read, synchronous write with per-byte enables.
module cache_array #(
    parameter int unsigned Width      = 8,
    parameter int unsigned Depth      = 8,
    parameter bit          Resettable = 1'b0,
    localparam int unsigned NumBytes  = (Width + 7) / 8,
    localparam int unsigned AddrWidth = $clog2(Depth)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [AddrWidth-1:0] index,
    input  logic [NumBytes-1:0]  we,
    input  logic [Width-1:0]     wdata,
    output logic [Width-1:0]     rdata
);

    logic [Width-1:0] mem_q [Depth];

    assign rdata = mem_q[index];

    // Byte-lane write; the top partial byte of a narrow array shares the last enable.
    always_ff @(posedge clk) begin
        if (Resettable && rst) begin
            for (int d = 0; d < int'(Depth); d++) begin
                mem_q[d] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(Width); i++) begin
                if (we[i / 8]) begin
                    mem_q[index][i] <= wdata[i];
                end
            end
        end
    end

endmodule

// File: rtl/l1_cache_2way.sv
// 2-way set-associative write-back, write-allocate cache between CPU and line memory.
module l1_cache_2way
    import cache_types::*;
(
    input  logic           clk,
    input  logic           rst,
    l1_cache_2way_if.slave bus
);

    localparam int unsigned LineBytes = line_bits / 8;
    localparam int unsigned TagBytes  = (s_tag + 7) / 8;

    cache_state_t state_q, state_d;
    logic         victim_q, victim_d;

    logic [s_tag-1:0]    req_tag;
    logic [s_index-1:0]  req_index;
    logic [word_sel-1:0] req_word;
    logic                req;
    logic                unused_addr;

    assign req_tag     = get_tag(bus.mem_address);
    assign req_index   = get_index(bus.mem_address);
    assign req_word    = get_word(bus.mem_address);
    assign req         = bus.mem_read | bus.mem_write;
    assign unused_addr = ^bus.mem_address[1:0];

    logic [line_bits-1:0] data_rd [2];
    logic [LineBytes-1:0] data_we [2];
    logic [line_bits-1:0] data_wd;
    logic [s_tag-1:0]     tag_rd  [2];
    logic                 tag_we  [2];
    logic                 valid_rd[2];
    logic                 valid_we[2];
    logic                 dirty_rd[2];
    logic                 dirty_we[2];
    logic                 dirty_wd;
    logic                 lru_rd, lru_we, lru_wd;
    logic [1:0]           hit;
    logic                 hit_any, hit_way, victim_sel;

    for (genvar w = 0; w < 2; w++) begin : g_way
        cache_array #(.Width(line_bits), .Depth(num_sets), .Resettable(1'b0)) u_data (
            .clk(clk), .rst(rst), .index(req_index),
            .we(data_we[w]), .wdata(data_wd), .rdata(data_rd[w])
        );
        cache_array #(.Width(s_tag), .Depth(num_sets), .Resettable(1'b0)) u_tag (
            .clk(clk), .rst(rst), .index(req_index),
            .we({TagBytes{tag_we[w]}}), .wdata(req_tag), .rdata(tag_rd[w])
        );
        cache_array #(.Width(1), .Depth(num_sets), .Resettable(1'b1)) u_valid (
            .clk(clk), .rst(rst), .index(req_index),
            .we(valid_we[w]), .wdata(1'b1), .rdata(valid_rd[w])
        );
        cache_array #(.Width(1), .Depth(num_sets), .Resettable(1'b1)) u_dirty (
            .clk(clk), .rst(rst), .index(req_index),
            .we(dirty_we[w]), .wdata(dirty_wd), .rdata(dirty_rd[w])
        );
        assign hit[w] = valid_rd[w] && (tag_rd[w] == req_tag);
    end

    cache_array #(.Width(1), .Depth(num_sets), .Resettable(1'b1)) u_lru (
        .clk(clk), .rst(rst), .index(req_index),
        .we(lru_we), .wdata(lru_wd), .rdata(lru_rd)
    );

    assign hit_any    = |hit;
    assign hit_way    = ~hit[0];
    // Fill an empty way first; only evict by lru once the set is full.
    assign victim_sel = !valid_rd[0] ? 1'b0 : (!valid_rd[1] ? 1'b1 : lru_rd);

    assign bus.mem_rdata  = data_rd[hit_way][{req_word, 5'b0} +: 32];
    assign bus.pmem_wdata = data_rd[victim_q];

    // FSM state and the victim way chosen on a miss.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            victim_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
        end
    end

    // Next state, handshake outputs and array write strobes.
    always_comb begin
        state_d          = state_q;
        victim_d         = victim_q;
        bus.mem_resp     = 1'b0;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = line_addr(req_tag, req_index);
        data_wd          = {(line_bits / 32){bus.mem_wdata}};
        dirty_wd         = 1'b0;
        lru_we           = 1'b0;
        lru_wd           = ~hit_way;
        for (int w = 0; w < 2; w++) begin
            data_we[w]  = '0;
            tag_we[w]   = 1'b0;
            valid_we[w] = 1'b0;
            dirty_we[w] = 1'b0;
        end
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (req && hit_any) begin
                        bus.mem_resp = 1'b1;
                        lru_we       = 1'b1;
                        if (bus.mem_write) begin
                            data_we[hit_way]  = LineBytes'(bus.mem_byte_enable) << {req_word, 2'b00};
                            dirty_we[hit_way] = 1'b1;
                            dirty_wd          = 1'b1;
                        end
                    end else if (req) begin
                        victim_d = victim_sel;
                        state_d  = (valid_rd[victim_sel] && dirty_rd[victim_sel]) ? WRITEBACK : FILL;
                    end
                end
                WRITEBACK: begin
                    bus.pmem_write   = 1'b1;
                    bus.pmem_address = line_addr(tag_rd[victim_q], req_index);
                    if (bus.pmem_resp) begin
                        state_d = FILL;
                    end
                end
                FILL: begin
                    bus.pmem_read = 1'b1;
                    if (bus.pmem_resp) begin
                        data_wd            = bus.pmem_rdata;
                        data_we[victim_q]  = '1;
                        tag_we[victim_q]   = 1'b1;
                        valid_we[victim_q] = 1'b1;
                        dirty_we[victim_q] = 1'b1;
                        state_d            = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l1_cache_2way.sv
// Randomised scoreboard bench for l1_cache_2way against a recency-list cache model.
module tb_l1_cache_2way;
    import cache_types::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    l1_cache_2way_if bus ();

    l1_cache_2way dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [255:0] line;
    } pmem_exp_t;

    typedef struct {
        logic        wr;
        logic [31:0] rdata;
        logic        hit;
    } resp_exp_t;

    typedef struct {
        logic [23:0] tag;
        bit          dirty;
    } res_t;

    pmem_exp_t pmem_q[$];
    resp_exp_t resp_q[$];
    res_t      res[8][$];     // per set, resident lines ordered most- to least-recent
    logic [31:0] gold [int unsigned];  // what the CPU should observe, by word address
    logic [31:0] phys [int unsigned];  // backing memory contents, by word address

    int delay_override = 0;
    bit stall_reads    = 0;

    function automatic logic [31:0] init_word(input int unsigned wa);
        return (wa * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    function automatic logic [31:0] gold_rd(input int unsigned wa);
        return gold.exists(wa) ? gold[wa] : init_word(wa);
    endfunction

    function automatic logic [31:0] phys_rd(input int unsigned wa);
        return phys.exists(wa) ? phys[wa] : init_word(wa);
    endfunction

    function automatic logic [255:0] gold_line(input logic [31:0] base);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = gold_rd((base >> 2) + w);
        return l;
    endfunction

    function automatic logic [255:0] phys_line(input logic [31:0] base);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = phys_rd((base >> 2) + w);
        return l;
    endfunction

    // Model: LRU over the two resident lines per set, write-back on dirty eviction.
    task automatic predict(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] be, output resp_exp_t r);
        logic [23:0] tag = addr[31:8];
        logic [2:0]  set = addr[7:5];
        int          found = -1;
        res_t        e;
        logic [31:0] word;
        for (int i = 0; i < res[set].size(); i++) if (res[set][i].tag == tag) found = i;
        if (found >= 0) begin
            e = res[set][found];
            res[set].delete(found);
            r.hit = 1'b1;
        end else begin
            r.hit = 1'b0;
            if (res[set].size() == 2) begin
                e = res[set][1];
                if (e.dirty) begin
                    pmem_q.push_back('{1'b1, {e.tag, set, 5'b0}, gold_line({e.tag, set, 5'b0})});
                end
                res[set].delete(1);
            end
            pmem_q.push_back('{1'b0, {tag, set, 5'b0}, 256'b0});
            e.tag   = tag;
            e.dirty = 1'b0;
        end
        e.dirty = e.dirty | wr;
        res[set].push_front(e);
        if (wr) begin
            word = gold_rd(addr >> 2);
            for (int b = 0; b < 4; b++) if (be[b]) word[b*8 +: 8] = wd[b*8 +: 8];
            gold[addr >> 2] = word;
        end
        r.wr    = wr;
        r.rdata = gold_rd(addr >> 2);
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be);
        resp_exp_t r;
        bit        got = 0;
        predict(wr, addr, wd, be, r);
        resp_q.push_back(r);
        @(posedge clk); #1;
        bus.mem_read        = !wr;
        bus.mem_write       = wr;
        bus.mem_address     = addr;
        bus.mem_wdata       = wd;
        bus.mem_byte_enable = be;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            got = bus.mem_resp;
        end
        if (!got) begin
            n_vec++;
            n_fail++;
            $display("FAIL resp_timeout: addr %h got no mem_resp, expected one", addr);
        end
        @(posedge clk); #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the cache responds.
    initial begin
        int        wait_cyc = 0;
        logic      prev_pmem_resp = 1'b0;
        logic      prev_resp = 1'b0;
        resp_exp_t r;
        forever begin
            @(negedge clk);
            check("pmem_exclusive", bus.pmem_read && bus.pmem_write, 0);
            if (bus.mem_resp) begin
                check("resp_single_pulse", prev_resp, 0);
                if (resp_q.size() == 0) begin
                    check("resp_expected", 0, 1);
                end else begin
                    r = resp_q.pop_front();
                    if (!r.wr) check("rdata", bus.mem_rdata, r.rdata);
                    check("hit_same_cycle", wait_cyc == 0, r.hit);
                    if (!r.hit) check("resp_after_fill", prev_pmem_resp, 1);
                end
                wait_cyc = 0;
            end else if (bus.mem_read || bus.mem_write) begin
                wait_cyc++;
            end else begin
                wait_cyc = 0;
            end
            prev_pmem_resp = bus.pmem_resp;
            prev_resp      = bus.mem_resp;
        end
    end

    // Physical memory responder: checks each line request against the model's prediction.
    initial begin
        bit          busy = 0;
        bit          resp_active = 0;
        bit          cur_wr = 0;
        logic [31:0] cur_addr = '0;
        int          cnt = 0;
        pmem_exp_t   e;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (resp_active) begin
                bus.pmem_resp = 1'b0;
                resp_active   = 0;
                busy          = 0;
            end
            if (busy && !(bus.pmem_read || bus.pmem_write)) begin
                busy = 0;
            end else if (!busy && (bus.pmem_read || bus.pmem_write)) begin
                if (pmem_q.size() == 0) begin
                    check("pmem_expected", 0, 1);
                end else begin
                    e = pmem_q.pop_front();
                    check("pmem_kind_write", bus.pmem_write, e.wr);
                    check("pmem_address", bus.pmem_address, e.addr);
                    if (e.wr) check("pmem_wdata", bus.pmem_wdata, e.line);
                end
                busy     = 1;
                cur_wr   = bus.pmem_write;
                cur_addr = bus.pmem_address;
                cnt      = (delay_override != 0) ? delay_override : int'($urandom_range(1, 6));
            end else if (busy && !(stall_reads && !cur_wr)) begin
                cnt--;
                if (cnt == 0) begin
                    if (cur_wr) begin
                        for (int w = 0; w < 8; w++) phys[(cur_addr >> 2) + w] = bus.pmem_wdata[w*32 +: 32];
                    end else begin
                        bus.pmem_rdata = phys_line(cur_addr);
                    end
                    bus.pmem_resp = 1'b1;
                    resp_active   = 1;
                end
            end
        end
    end

    // Illegal CPU request encoding.
    always @(negedge clk) begin
        assert (!(bus.mem_read && bus.mem_write)) else $error("mem_read and mem_write together");
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at time %0t, expected to finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        resp_exp_t   dummy;
        logic [31:0] a;
        bit          seen;
        rst                 = 1'b1;
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_address     = '0;
        bus.mem_wdata       = '0;
        bus.mem_byte_enable = '0;
        phys[32'h104 >> 2]  = 32'hDEAD_BEEF;
        gold[32'h104 >> 2]  = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_mem_resp", bus.mem_resp, 0);
        check("reset_pmem_read", bus.pmem_read, 0);
        check("reset_pmem_write", bus.pmem_write, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_pmem_read", bus.pmem_read, 0);
        check("idle_pmem_write", bus.pmem_write, 0);

        // Cold fill, repeat hit, byte-masked write, dirty eviction across three tags.
        delay_override = 5;
        issue(1'b0, 32'h0000_0104, 32'h0, 4'h0);
        issue(1'b0, 32'h0000_0104, 32'h0, 4'h0);
        issue(1'b1, 32'h0000_0104, 32'h1122_3344, 4'b0101);
        issue(1'b0, 32'h0000_0104, 32'h0, 4'h0);
        issue(1'b0, 32'h0000_1104, 32'h0, 4'h0);
        issue(1'b0, 32'h0000_2104, 32'h0, 4'h0);
        // lru: alternate two tags, then a third evicts the one touched least recently.
        issue(1'b0, 32'h0000_0020, 32'h0, 4'h0);
        issue(1'b0, 32'h0000_0120, 32'h0, 4'h0);
        issue(1'b0, 32'h0000_0020, 32'h0, 4'h0);
        issue(1'b0, 32'h0000_0120, 32'h0, 4'h0);
        issue(1'b0, 32'h0000_0020, 32'h0, 4'h0);
        issue(1'b0, 32'h0000_0220, 32'h0, 4'h0);
        issue(1'b0, 32'h0000_0020, 32'h0, 4'h0);
        issue(1'b0, 32'h0000_0120, 32'h0, 4'h0);
        delay_override = 0;

        for (int n = 0; n < 400; n++) begin
            a = {22'($urandom_range(0, 3)), 10'($urandom)};
            issue(($urandom % 3) == 0, a, $urandom, 4'($urandom));
        end

        // Reset while a fill is outstanding.
        stall_reads = 1;
        a = 32'h0000_7760;
        predict(1'b0, a, 32'h0, 4'h0, dummy);
        @(posedge clk); #1;
        bus.mem_read    = 1'b1;
        bus.mem_address = a;
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            seen = bus.pmem_read;
        end
        check("rst_test_fill_started", seen, 1);
        @(posedge clk); #1;
        rst          = 1'b1;
        bus.mem_read = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_fill_pmem_read", bus.pmem_read, 0);
        check("rst_mid_fill_pmem_write", bus.pmem_write, 0);
        check("rst_mid_fill_mem_resp", bus.mem_resp, 0);
        stall_reads = 0;
        check("rst_pmem_queue_drained", pmem_q.size(), 0);
        for (int s = 0; s < 8; s++) res[s].delete();
        gold = phys;    // unflushed dirty data is lost with the valid bits
        issue(1'b0, a, 32'h0, 4'h0);
        issue(1'b0, 32'h0000_0104, 32'h0, 4'h0);

        for (int n = 0; n < 100; n++) begin
            a = {22'($urandom_range(0, 3)), 10'($urandom)};
            issue(($urandom % 3) == 0, a, $urandom, 4'($urandom));
        end

        repeat (5) @(posedge clk);
        check("resp_queue_empty", resp_q.size(), 0);
        check("pmem_queue_empty", pmem_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/l1_cache_2way.md
Name: l1_cache_2way

Overview:
- Unified 2-way set-associative, write-back, write-allocate cache.
- Sits directly downstream of the multicycle RV32I CPU.
- Slave side: accepts the CPU's word-wide mem_read/mem_write/mem_byte_enable/mem_address/mem_wdata handshake and returns mem_rdata/mem_resp.
- Master side: issues whole 256-bit line transfers to physical memory.

Parameters:
- s_index, 3: index bits; 8 sets.
- s_offset, 5: byte-offset bits; 32-byte (256-bit) lines.
- s_tag, 32-s_offset-s_index (24): tag bits; derived, not overridable.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- mem_read  in  1  CPU read request; held until mem_resp
- mem_write  in  1  CPU write request; held until mem_resp
- mem_byte_enable  in  4  byte lanes written on a write
- mem_address  in  32  CPU byte address; bits [1:0] ignored
- mem_wdata  in  32  CPU write data
- mem_rdata  out  32  read word
- mem_resp  out  1  one-cycle completion pulse
- pmem_read  out  1  line fill request; held until pmem_resp
- pmem_write  out  1  line writeback request; held until pmem_resp
- pmem_address  out  32  line-aligned address; bits [4:0] = 0
- pmem_wdata  out  256  victim line
- pmem_rdata  in  256  fill line
- pmem_resp  in  1  physical memory completion

Behaviour:
- Address split: tag = [31:8], index = [7:5], word select = [4:2].
- Per-way, per-set state: valid, dirty, tag, and 256-bit data.
- Per-set state: one lru bit, which names the way to evict next.
- Reset (synchronous):
  - state <= IDLE; all valid, dirty and lru <= 0.
  - Outputs during and after reset: mem_resp = 0, pmem_read = 0, pmem_write = 0.
  - Data and tag arrays are not reset.
- Reset asserted mid-miss: the FSM returns to IDLE on that edge; pmem_read/pmem_write drop in the following cycle; the in-flight transfer is abandoned.
- FSM states: IDLE, WRITEBACK, FILL.
- IDLE: tag compare is combinational against both ways of the set.
  - Hit (valid && tag match, either way) → mem_resp = 1 in the same cycle the request is present. No state change.
  - Read hit: mem_rdata = selected word, combinational.
  - Write hit: at the edge, merge each byte lane i where mem_byte_enable[i] = 1 into the selected word; set dirty = 1.
  - Any hit: lru <= ~hit_way at the edge.
  - Miss: choose the victim (see below). Victim valid && dirty → WRITEBACK, else → FILL. mem_resp = 0.
- Victim selection: first invalid way (way 0 before way 1); if both ways are valid, way = lru.
- WRITEBACK:
  - pmem_write = 1, pmem_address = {victim tag, index, 5'b0}, pmem_wdata = victim line.
  - Hold all three until pmem_resp, then → FILL.
- FILL:
  - pmem_read = 1, pmem_address = {request tag, index, 5'b0}.
  - On pmem_resp: write pmem_rdata into the victim way; valid <= 1, dirty <= 0, tag <= request tag; → IDLE.
  - The re-lookup in IDLE hits and responds; that hit performs the write merge/lru update.
  - Miss latency = (WRITEBACK cycles) + (FILL cycles) + 1.
- Victim way is registered on the IDLE→miss transition and held through WRITEBACK/FILL. The request address is not re-sampled; the CPU must hold it stable.
- pmem_read and pmem_write are never asserted together. Both are 0 in IDLE.
- mem_resp is never asserted outside IDLE and never in consecutive cycles for one request; the CPU drops the request the cycle after mem_resp.
- mem_read && mem_write together is illegal; the bench flags it with an assertion. The RTL treats the request as a write.
- mem_rdata is don't-care when mem_resp = 0 or on writes.

Decomposition:
- Package cache_types:
  - s_index/s_offset/s_tag constants;
  - cache_state_t enum {IDLE, WRITEBACK, FILL};
  - address-field extraction functions.
- One sub-module: cache_array.
  - Parameterized width × 8-entry register array.
  - Async read, sync write with per-byte write enable.
  - Instantiated for data (256-bit), tag (24-bit), valid, dirty and lru.
- The top holds the FSM, compare, victim select and merge logic.

Test Plan:
1. Cold read 0x0000_0104; pmem returns line with word1 = 0xDEAD_BEEF after 5 cycles → FILL with pmem_address 0x0000_0100; mem_resp one cycle after pmem_resp; mem_rdata = 0xDEAD_BEEF; no pmem_write.
2. Repeat read 0x0000_0104 → mem_resp same cycle; pmem_read stays 0.
3. Write 0x0000_0104, wdata 0x1122_3344, byte_enable 4'b0101 → hit; next read returns 0xDE22_BE44; dirty set.
4. Read 0x0000_1104 then 0x0000_2104 (same set 0, three tags) → the second fill evicts the dirty way holding tag 0x000001. pmem_write asserted first with pmem_address 0x0000_0100 and word1 = 0xDE22_BE44, then FILL at 0x0000_2100.
5. Alternate hits on two resident tags, then miss on a third → the evicted way is the one not touched last, per lru.
6. Assert rst during FILL before pmem_resp → next cycle pmem_read = 0, state IDLE; re-read of the same address misses (all valid cleared).
